cq_serializer: RTL
==================

CQ_SERIALIZER -- requirements
Module: cq_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit time; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 empty  input  1  queue-empty flag from the upstream circular queue.
REQ-005 din  input  16  queue head word; combinational read of current read address.
REQ-006 rd  output  1  pop request to queue; queue read pointer advances at the same clock edge.
REQ-007 tx  output  1  serial line; idle level high.
REQ-008 busy  output  1  high while a frame is in flight (any state except IDLE).
REQ-009 done  output  1  single-cycle pulse in the last cycle of STOP.

Function
REQ-010 FSM states: IDLE, START, DATA, STOP; encoding fixed in the shared package.
REQ-011 IDLE: rd = !empty, combinational, asserted only in IDLE.
REQ-012 IDLE with empty=0: at the same edge, latch din into a 16-bit shift register, clear bit and cycle counters, go to START.
REQ-013 IDLE with empty=1: remain in IDLE, rd=0, tx=1.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA: 16 bits, LSB first; tx = shift register bit 0; each bit held CLKS_PER_BIT cycles, then shift right by one.
REQ-016 DATA exits to STOP after bit 15 completes its CLKS_PER_BIT cycles; bit counter is 4 bits and terminates at 15, no wrap.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles; done=1 in the final cycle; then go to IDLE.
REQ-018 Frame length is 18*CLKS_PER_BIT cycles; back-to-back frames are separated by exactly one IDLE cycle (period 18*CLKS_PER_BIT+1).
REQ-019 rd is asserted at most once per frame; no pop is issued while busy=1.
REQ-020 din and empty are ignored outside IDLE; upstream writes during a frame do not affect the word in flight.
REQ-021 tx is driven from a register (glitch-free); rd is the only combinational output.
REQ-022 Cycle counter width is ceil(log2(CLKS_PER_BIT)) bits; it resets to 0 at every bit boundary.

Reset
REQ-023 With reset=1 at an edge: state=IDLE, tx=1, busy=0, done=0, shift register=0, counters=0.
REQ-024 rd=0 whenever reset=1, regardless of empty.
REQ-025 Reset mid-frame aborts the frame: tx returns high on the next edge, the popped word is lost, and no re-pop occurs until reset deasserts.

Structure
REQ-026 Shared package holds the state encoding, the DATA_BITS=16 and FRAME_BITS=18 constants, and the CLKS_PER_BIT default.
REQ-027 One sub-module, bit_timer: a CLKS_PER_BIT modulo counter with clear input and terminal-count output, instantiated once.
REQ-028 Top-level output port order matches the queue's wr/rd conventions, so cq_serializer connects directly to cq empty/dout/rd.

Verification
REQ-029 Single word: reset, then empty=0, din=16'hA5C3 for one IDLE cycle -> rd=1 one cycle; tx = 0, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1, each held 4 cycles; done pulse at cycle 72.
REQ-030 Back-to-back: queue holds 16'h0001, 16'h8000 -> two frames, one IDLE cycle between; rd pulses exactly 73 cycles apart; bit 0 and bit 15 are the only low-to-high data bits.
REQ-031 Empty hold-off: empty=1 for 50 cycles -> rd=0, tx=1, busy=0 throughout.
REQ-032 Reset mid-DATA: reset at cycle 30 of a frame -> next edge tx=1, busy=0; no rd while reset=1; a new frame starts on the first IDLE cycle with empty=0 after reset deasserts.
REQ-033 Input isolation: toggle din and empty every cycle during a frame -> tx sequence unchanged from the latched word; rd stays 0 until IDLE.
REQ-034 CLKS_PER_BIT=2 build: 16'hFFFF -> frame of 36 cycles; start bit low for 2 cycles, then tx high for 34 cycles.

Source files
------------

// File: rtl/cq_serializer_pkg.sv
// Shared definitions for the queue-fed serializer: FSM encoding and frame geometry.
package cq_serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int DATA_BITS        = 16;
  localparam int FRAME_BITS       = DATA_BITS + 2;  // start + data + stop
  localparam int CLKS_PER_BIT_DEF = 4;
  localparam int BIT_CNT_W        = $clog2(DATA_BITS);

endpackage

// File: rtl/cq_serializer_if.sv
// Queue read port as seen by the serializer: empty flag, head word, pop strobe.
interface cq_serializer_if;

  logic                                 empty;
  logic [cq_serializer_pkg::DATA_BITS-1:0] din;
  logic                                 rd;

  // master = the circular queue, slave = the serializer draining it
  modport master (output empty, output din, input rd);
  modport slave  (input empty, input din, output rd);

endinterface

// File: rtl/cq_serializer_bit_timer.sv
// Modulo-CLKS_PER_BIT cycle counter with synchronous clear and terminal-count flag.
module cq_serializer_bit_timer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tc) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cq_serializer.sv
// Pops 16-bit words from a circular queue and sends each as a start/16-data/stop frame, LSB first.
module cq_serializer
    import cq_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    cq_serializer_if.slave   q,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int                   CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]     PRE_TC   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    logic [1:0]           state;
    logic [DATA_BITS-1:0] shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0]     cyc_cnt;
    logic                 bit_tc;

    // NOTE: rd feeds the queue's pointer update directly, so it is gated by reset
    // here rather than relying on state, which only becomes IDLE one edge later.
    assign q.rd = (state == ST_IDLE) && !q.empty && !reset;

    // Held cleared through IDLE so the first START cycle always begins at count 0.
    cq_serializer_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_IDLE),
        .count (cyc_cnt),
        .tc    (bit_tc)
    );

    // tx/busy/done are registered: each branch loads the value for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!q.empty) begin
                        shreg   <= q.din;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tc) begin
                        tx    <= shreg[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tc) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    // Raised one cycle early so the registered pulse lands on the last STOP cycle.
                    if (cyc_cnt == PRE_TC) begin
                        done <= 1'b1;
                    end
                    if (bit_tc) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
